// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: the memory end of the CPU instruction-fetch interface.
//
// The fetch path raises readM with a word address. After LATENCY edges the word held in
// the ROM at address[ADDR_BITS-1:0] appears on data, and inputReady pulses high for exactly
// one cycle. The FSM returns to IDLE in that same cycle, so a requester that keeps readM high
// in the inputReady cycle starts a back-to-back fetch. One request is served every
// LATENCY+1 cycles.
//
// A side load port writes the ROM. It works in any FSM state and is ignored during reset.
// Reset does not clear the ROM.
//
// Parameters
//   WORD_SIZE  instruction/address word width
//   ADDR_BITS  ROM index width (DEPTH = 2**ADDR_BITS)
//   LATENCY    request-sample to response edges, legal range 1..15
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   readM       fetch request, held until inputReady is seen
//   address     fetch word address; upper bits ignored
//   data        registered instruction word; holds until the next response
//   inputReady  one-cycle pulse: data valid this cycle
//   load_en     ROM write strobe
//   load_addr   ROM write index
//   load_data   ROM write data

module instr_mem_responder #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [WORD_SIZE-1:0] load_data
);

    localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 ready_q, ready_d;

    logic [WORD_SIZE-1:0] rom [DEPTH];

    // Address bits above the ROM index are deliberately dropped (index wraps modulo DEPTH).
    if (WORD_SIZE > ADDR_BITS) begin : g_addr_unused
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
    end

    // ROM array is not reset; only the write strobe is gated by reset.
    always_ff @(posedge clk) begin
        if (reset_n && load_en) begin
            rom[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        data_d     = data_q;
        ready_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (readM) begin
                    req_addr_d = address[ADDR_BITS-1:0];
                    cnt_d      = CNT_INIT;
                    state_d    = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // Abort takes priority: a dropped request never produces a pulse.
                if (!readM) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // ROM read happens here, so a load at this same edge is not yet visible.
                data_d  = rom[req_addr_q];
                ready_d = 1'b1;
                // IDLE during the pulse cycle lets a held readM start the next fetch.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_addr_q <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
        end
    end

    assign data       = data_q;
    assign inputReady = ready_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance.

module tb_instr_mem_responder;

    logic        clk;
    logic        reset_n;

    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    logic        readM1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        inputReady1;
    logic        load_en1;
    logic [7:0]  load_addr1;
    logic [15:0] load_data1;

    int checks = 0;
    int errors = 0;

    instr_mem_responder #(
        .WORD_SIZE (16),
        .ADDR_BITS (8),
        .LATENCY   (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .readM      (readM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    instr_mem_responder #(
        .WORD_SIZE (16),
        .ADDR_BITS (8),
        .LATENCY   (1)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .readM      (readM1),
        .address    (address1),
        .data       (data1),
        .inputReady (inputReady1),
        .load_en    (load_en1),
        .load_addr  (load_addr1),
        .load_data  (load_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load1(input logic [7:0] a, input logic [15:0] d);
        load_en1   = 1'b1;
        load_addr1 = a;
        load_data1 = d;
        tick();
        load_en1   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        readM      = 1'b0;
        address    = '0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        readM1     = 1'b0;
        address1   = '0;
        load_en1   = 1'b0;
        load_addr1 = '0;
        load_data1 = '0;
        tick();
        tick();
        chk("reset_ready", {15'd0, inputReady}, 16'd0);
        chk("reset_data", data, 16'h0000);
        chk("reset_ready_l1", {15'd0, inputReady1}, 16'd0);
        chk("reset_data_l1", data1, 16'h0000);
        reset_n = 1'b1;

        load(8'h05, 16'hA123);
        load(8'h10, 16'h7777);
        load(8'h00, 16'h0001);
        load(8'h01, 16'h0002);
        load(8'h02, 16'h0003);
        load(8'h20, 16'h0BEE);
        load(8'h30, 16'h5A5A);
        load1(8'h03, 16'h1234);

        // 1) Basic fetch, latency 2.
        readM   = 1'b1;
        address = 16'h0005;
        tick();
        chk("t1_ready_t0", {15'd0, inputReady}, 16'd0);
        address = 16'h0010;  // must not disturb the pending response
        tick();
        chk("t1_ready_t1", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t1_ready_t2", {15'd0, inputReady}, 16'd1);
        chk("t1_data", data, 16'hA123);
        readM = 1'b0;
        tick();
        chk("t1_ready_t3", {15'd0, inputReady}, 16'd0);
        chk("t1_data_hold", data, 16'hA123);

        // 2) Upper address bits ignored.
        readM   = 1'b1;
        address = 16'hF110;
        tick();
        tick();
        tick();
        chk("t2_ready", {15'd0, inputReady}, 16'd1);
        chk("t2_data", data, 16'h7777);
        readM = 1'b0;
        tick();

        // 3) Back-to-back with readM held high.
        readM   = 1'b1;
        address = 16'h0000;
        tick();
        tick();
        chk("t3_gap0", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t3_pulse0", {15'd0, inputReady}, 16'd1);
        chk("t3_data0", data, 16'h0001);
        address = 16'h0001;
        tick();
        chk("t3_gap1a", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t3_gap1b", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t3_pulse1", {15'd0, inputReady}, 16'd1);
        chk("t3_data1", data, 16'h0002);
        address = 16'h0002;
        tick();
        chk("t3_gap2a", {15'd0, inputReady}, 16'd0);
        tick();
        tick();
        chk("t3_pulse2", {15'd0, inputReady}, 16'd1);
        chk("t3_data2", data, 16'h0003);
        readM = 1'b0;
        tick();
        chk("t3_end", {15'd0, inputReady}, 16'd0);

        // 4) Abort during WAIT.
        readM   = 1'b1;
        address = 16'h0020;
        tick();
        readM = 1'b0;
        tick();
        chk("t4_abort_a", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t4_abort_b", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t4_abort_c", {15'd0, inputReady}, 16'd0);
        chk("t4_data_kept", data, 16'h0003);
        readM   = 1'b1;
        address = 16'h0030;
        tick();
        tick();
        tick();
        chk("t4_next_ready", {15'd0, inputReady}, 16'd1);
        chk("t4_next_data", data, 16'h5A5A);
        readM = 1'b0;
        tick();

        // 5) Reset at the WAIT edge; a load during reset is ignored.
        readM   = 1'b1;
        address = 16'h0005;
        tick();
        reset_n   = 1'b0;
        load_en   = 1'b1;
        load_addr = 8'h05;
        load_data = 16'hDEAD;
        tick();
        load_en = 1'b0;
        chk("t5_rst_ready", {15'd0, inputReady}, 16'd0);
        chk("t5_rst_data", data, 16'h0000);
        reset_n = 1'b1;
        readM   = 1'b0;
        tick();
        chk("t5_post_ready_a", {15'd0, inputReady}, 16'd0);
        tick();
        chk("t5_post_ready_b", {15'd0, inputReady}, 16'd0);
        chk("t5_post_data", data, 16'h0000);
        readM = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_rom_ready", {15'd0, inputReady}, 16'd1);
        chk("t5_rom_kept", data, 16'hA123);
        readM = 1'b0;
        tick();

        // 7) Load at the RESP edge returns the old word; an earlier load is visible.
        readM   = 1'b1;
        address = 16'h0030;
        tick();
        tick();
        load_en   = 1'b1;
        load_addr = 8'h30;
        load_data = 16'h1111;
        tick();
        load_en = 1'b0;
        chk("t7_same_edge_ready", {15'd0, inputReady}, 16'd1);
        chk("t7_same_edge_old", data, 16'h5A5A);
        readM = 1'b0;
        tick();
        readM = 1'b1;
        tick();
        tick();
        tick();
        chk("t7_new_word", data, 16'h1111);
        readM = 1'b0;
        tick();
        readM   = 1'b1;
        address = 16'h0010;
        tick();
        load_en   = 1'b1;
        load_addr = 8'h10;
        load_data = 16'h2222;
        tick();
        load_en = 1'b0;
        tick();
        chk("t7_early_ready", {15'd0, inputReady}, 16'd1);
        chk("t7_early_load", data, 16'h2222);
        readM = 1'b0;
        tick();

        // 6) LATENCY=1 instance.
        readM1   = 1'b1;
        address1 = 16'h0003;
        tick();
        chk("t6_ready_t0", {15'd0, inputReady1}, 16'd0);
        tick();
        chk("t6_ready_t1", {15'd0, inputReady1}, 16'd1);
        chk("t6_data", data1, 16'h1234);
        readM1 = 1'b0;
        tick();
        chk("t6_ready_t2", {15'd0, inputReady1}, 16'd0);
        readM1     = 1'b1;
        load_en1   = 1'b1;
        load_addr1 = 8'h03;
        load_data1 = 16'hABCD;
        tick();
        load_en1 = 1'b0;
        chk("t6_load_ready_t0", {15'd0, inputReady1}, 16'd0);
        tick();
        chk("t6_load_ready_t1", {15'd0, inputReady1}, 16'd1);
        chk("t6_load_data", data1, 16'hABCD);
        readM1 = 1'b0;
        tick();
        chk("t6_end", {15'd0, inputReady1}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
